queen_search_controller: RTL

//   Sequencing FSM for the stacked N-queen solver datapath. Walks columns
//   0..N-1 and offers candidate rows to an external conflict checker.

---
 rtl/queen_search_controller.sv | 134 +++++++++++++
 1 files changed

// File: rtl/queen_search_controller.sv
// Sequencing FSM for the stacked N-queen solver: offers candidate rows to an
// external conflict checker, pushes/pops the external row stack, streams the board.
module queen_search_controller #(
    parameter int N     = 8,
    parameter int ROW_W = 3
) (
    input  logic             clk,
    input  logic             user_reset,
    input  logic             start,
    output logic             chk_req,
    output logic [ROW_W-1:0] cand_row,
    output logic [ROW_W-1:0] cand_col,
    input  logic             chk_ack,
    input  logic             chk_conflict,
    output logic             stk_push,
    output logic             stk_pop,
    input  logic [ROW_W-1:0] stk_top,
    output logic [ROW_W-1:0] stk_rd_idx,
    input  logic [ROW_W-1:0] stk_rd_data,
    output logic [N-1:0]     out_bus,
    output logic             out_valid,
    output logic             ready,
    output logic             done,
    output logic             no_answer
);
    localparam int               DEPTH_W = ROW_W + 1;
    localparam logic [ROW_W-1:0] LAST    = ROW_W'(N - 1);

    typedef enum logic [2:0] {IDLE, CHECK, BACKTRACK, OUTPUT, DONE, FAIL} state_t;

    state_t             state;
    logic [DEPTH_W-1:0] depth;
    logic               start_d;
    logic               start_acc;

    function automatic logic [N-1:0] row_onehot(input logic [ROW_W-1:0] row);
        return N'(1) << row;
    endfunction

    assign start_acc = start && !start_d &&
                       ((state == IDLE) || (state == DONE) || (state == FAIL));
    assign cand_col  = depth[ROW_W-1:0];

    // A push or pop issued on one edge only lands in the stack on the next edge,
    // so the cycle after each stack operation is spent waiting before the stack
    // is consulted again (checker request, stk_top, stk_rd_data).
    always_ff @(posedge clk or posedge user_reset) begin
        if (user_reset) begin
            state      <= IDLE;
            ready      <= 1'b1;
            depth      <= '0;
            cand_row   <= '0;
            start_d    <= 1'b0;
            chk_req    <= 1'b0;
            stk_push   <= 1'b0;
            stk_pop    <= 1'b0;
            stk_rd_idx <= '0;
            out_bus    <= '0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            no_answer  <= 1'b0;
        end else begin
            start_d  <= start;
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
            if (start_acc) begin
                state     <= CHECK;
                depth     <= '0;
                cand_row  <= '0;
                chk_req   <= 1'b0;
                ready     <= 1'b0;
                done      <= 1'b0;
                no_answer <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    CHECK: begin
                        if (!chk_req) begin
                            // cand_row is held through the push cycle so the stack captures it
                            if (stk_push) cand_row <= '0;
                            chk_req <= 1'b1;
                        end else if (chk_ack) begin
                            chk_req <= 1'b0;
                            if (!chk_conflict) begin
                                stk_push <= 1'b1;
                                depth    <= depth + DEPTH_W'(1);
                                if (depth == DEPTH_W'(N - 1)) begin
                                    state      <= OUTPUT;
                                    stk_rd_idx <= '0;
                                end
                            end else if (cand_row != LAST) begin
                                cand_row <= cand_row + ROW_W'(1);
                            end else begin
                                state <= BACKTRACK;
                            end
                        end
                    end
                    BACKTRACK: begin
                        if (!stk_pop) begin
                            if (depth == '0) begin
                                state     <= FAIL;
                                done      <= 1'b1;
                                no_answer <= 1'b1;
                                ready     <= 1'b1;
                            end else begin
                                stk_pop <= 1'b1;
                                depth   <= depth - DEPTH_W'(1);
                                if (stk_top != LAST) begin
                                    cand_row <= stk_top + ROW_W'(1);
                                    state    <= CHECK;
                                end
                            end
                        end
                    end
                    OUTPUT: begin
                        if (!stk_push) begin
                            out_bus   <= row_onehot(stk_rd_data);
                            out_valid <= 1'b1;
                            if (stk_rd_idx == LAST) begin
                                state <= DONE;
                                done  <= 1'b1;
                                ready <= 1'b1;
                            end else begin
                                stk_rd_idx <= stk_rd_idx + ROW_W'(1);
                            end
                        end
                    end
                    DONE: out_valid <= 1'b0;
                    default: ;
                endcase
            end
        end
    end
endmodule
